// File: rtl/booth_seq_mul_ctrl_pkg.sv
// mul_pkg: shared types and helpers for the sequential Booth multiplier.
//   state_e        : controller state (IDLE, RUN, DONE)
//   BOOTH_ADD/SUB  : decode of {Q[0], Q_-1} selecting A+M / A-M
//   overflow_check : does a 2w-bit product {hi,lo} fit in w bits
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Widest operand the overflow helper supports.
  localparam int MAX_W = 64;

  // Signed: product fits when hi is the sign extension of lo[w-1].
  // Unsigned: product fits when hi is zero. Only the low w bits of hi/lo count.
  function automatic logic overflow_check(input logic sgn,
                                          input logic [MAX_W-1:0] hi,
                                          input logic [MAX_W-1:0] lo,
                                          input int w);
    logic ext;
    logic res;
    ext = 1'b0;
    res = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) ext = sgn & lo[i];
    end
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w && hi[i] != ext) res = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/booth_seq_mul_ctrl_if.sv
// Bus between the execute stage and the multiply unit.
//   Requests : start, is_signed, m, r, abort, hi_we, lo_we, wdata
//   Status   : busy, done, hi, lo, overflow, state (debug view of the FSM)
// Handshake: a request is a single-cycle start pulse; it is taken only when
// the unit is in IDLE or DONE (and, in IDLE, abort is low). There is no
// ready/queueing: a start seen while busy=1 is dropped. done pulses for one
// cycle when hi/lo hold the new product.
interface booth_seq_mul_ctrl_if
  import mul_pkg::*;
#(
  parameter int WWidth = 32
) ();

  logic              start;
  logic              is_signed;
  logic [WWidth-1:0] m;
  logic [WWidth-1:0] r;
  logic              abort;
  logic              hi_we;
  logic              lo_we;
  logic [WWidth-1:0] wdata;
  logic              busy;
  logic              done;
  logic [WWidth-1:0] hi;
  logic [WWidth-1:0] lo;
  logic              overflow;
  state_e            state;

  modport master (
    output start, is_signed, m, r, abort, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, overflow, state
  );

  modport slave (
    input  start, is_signed, m, r, abort, hi_we, lo_we, wdata,
    output busy, done, hi, lo, overflow, state
  );

endinterface

// File: rtl/booth_seq_mul_ctrl_booth_step.sv
// booth_step: one radix-2 Booth iteration, purely combinational.
//   a, q, q_m1, m               : current partial state (WWidth+1-bit A, Q, M)
//   a_next, q_next, q_m1_next   : state after add/sub and arithmetic shift
module booth_step
  import mul_pkg::*;
#(
  parameter int WWidth = 32
) (
  input  logic [WWidth:0] a,
  input  logic [WWidth:0] q,
  input  logic            q_m1,
  input  logic [WWidth:0] m,
  output logic [WWidth:0] a_next,
  output logic [WWidth:0] q_next,
  output logic            q_m1_next
);

  logic [WWidth:0] sum;

  always_comb begin
    case ({q[0], q_m1})
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a - m;
      default:   sum = a;
    endcase
    // Arithmetic shift of {sum, q, q_m1} right by one.
    a_next    = {sum[WWidth], sum[WWidth:1]};
    q_next    = {sum[0], q[WWidth:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// booth_seq_mul_ctrl: sequential radix-2 Booth multiplier with HI/LO registers.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of booth_seq_mul_ctrl_if (requests in, HI/LO and
//                status out). Operands are extended to WWidth+1 bits so the
//                same datapath serves MULT and MULTU; WWidth+1 steps are run.
module booth_seq_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WWidth   = 32,
  parameter int CntWidth = 6
) (
  input logic                 clk,
  input logic                 reset,
  booth_seq_mul_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [WWidth:0]     a_q, a_d, q_q, q_d, m_q, m_d;
  logic                qm1_q, qm1_d;
  logic                sgn_q, sgn_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [WWidth-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [WWidth:0]     step_a, step_q;
  logic                step_qm1;
  logic [WWidth-1:0]   hi_new, lo_new;

  booth_step #(.WWidth(WWidth)) u_step (
    .a         (a_q),
    .q         (q_q),
    .q_m1      (qm1_q),
    .m         (m_q),
    .a_next    (step_a),
    .q_next    (step_q),
    .q_m1_next (step_qm1)
  );

  // Low 2*WWidth bits of {A,Q} after the final step.
  assign hi_new = {step_a[WWidth-2:0], step_q[WWidth]};
  assign lo_new = step_q[WWidth-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // abort only vetoes a start while IDLE; in DONE it has no effect.
        if (bus.start && !(state_q == IDLE && bus.abort)) begin
          a_d     = '0;
          q_d     = {bus.is_signed & bus.r[WWidth-1], bus.r};
          m_d     = {bus.is_signed & bus.m[WWidth-1], bus.m};
          qm1_d   = 1'b0;
          sgn_d   = bus.is_signed;
          cnt_d   = CntWidth'(WWidth + 1);
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          a_d   = step_a;
          q_d   = step_q;
          qm1_d = step_qm1;
          cnt_d = cnt_q - CntWidth'(1);
          if (cnt_q == CntWidth'(1)) begin
            hi_d    = hi_new;
            lo_d    = lo_new;
            ovf_d   = overflow_check(sgn_q, MAX_W'(hi_new), MAX_W'(lo_new), WWidth);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.overflow = ovf_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
module tb_booth_seq_mul_ctrl;
  import mul_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  booth_seq_mul_ctrl_if #(.WWidth(W)) bus ();

  booth_seq_mul_ctrl #(.WWidth(W), .CntWidth(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, result packed as {overflow, hi, lo}.
  function automatic logic [2*W:0] ref_mul(input logic sgn, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint     p;
    logic [63:0] u;
    logic        ovf;
    if (sgn) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      u   = p;
      ovf = (u[63:32] != {32{u[31]}});
    end else begin
      u   = {32'b0, a} * {32'b0, b};
      ovf = (u[63:32] != 32'b0);
    end
    return {ovf, u};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending product");
      end else begin
        mon_e = exp_q.pop_front();
        chk("product", {bus.hi, bus.lo}, mon_e[63:0]);
        chk("overflow", 64'(bus.overflow), 64'(mon_e[64]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  // Present a start for one cycle; returns just after the accepting edge.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.m         = a;
    bus.r         = b;
    if (push) exp_q.push_back(ref_mul(sgn, a, b));
    tick();
    bus.start = 1'b0;
  endtask

  // Counts cycles until done; returns at the negedge of the done cycle.
  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    int busy_n = 0;
    bit seen = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        n = i;
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in 60 cycles expected done after %0d", name, exp_lat);
    end else begin
      chk({name, "_latency"}, 64'(n), 64'(exp_lat));
      chk({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    end
  endtask

  logic [W-1:0] corners[8];

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return corners[$urandom_range(0, 7)];
      1: return W'($urandom_range(0, 255)) - W'(128);
      default: return $urandom();
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF; corners[5] = 32'h0001_0000;
    corners[6] = 32'hFFFF_0000; corners[7] = 32'h8000_0001;

    reset = 1'b1;
    clear_inputs();
    bus.is_signed = 1'b0;
    bus.m = '0;
    bus.r = '0;
    bus.wdata = '0;
    repeat (3) tick();
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_ovf", 64'(bus.overflow), 64'd0);
    chk("reset_state", 64'(bus.state), 64'(IDLE));
    reset = 1'b0;
    tick();

    // Signed 7 * -3
    issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    wait_done("s7xm3", LAT);
    chk("s7xm3_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    chk("s7xm3_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
    tick();
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("back_to_idle", 64'(bus.state), 64'(IDLE));

    // Overflow corners, then a back-to-back start in the DONE cycle.
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("s_min_sq", LAT);
    chk("s_min_sq_ovf", 64'(bus.overflow), 64'd1);
    tick();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("u_max_sq", LAT);
    chk("u_max_sq_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    chk("b2b_ovf_cleared", 64'(bus.overflow), 64'd0);
    wait_done("b2b", LAT);

    // Second start with hi_we at cycle 10 is ignored.
    tick();
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (9) tick();
    bus.start = 1'b1;
    bus.is_signed = 1'b1;
    bus.m = 32'h0000_0003;
    bus.r = 32'h0000_0005;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    tick();
    clear_inputs();
    wait_done("ignored_start", LAT - 10);
    tick();

    // MTHI/MTLO preload, then abort at cycle 20.
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234; tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h0000_5678; tick();
    clear_inputs();
    chk("mthi", 64'(bus.hi), 64'h1234);
    chk("mtlo", 64'(bus.lo), 64'h5678);
    issue(1'b1, 32'h0000_0009, 32'h0000_0009, 1'b0);
    repeat (19) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_state", 64'(bus.state), 64'(IDLE));
    chk("abort_hi", 64'(bus.hi), 64'h1234);
    chk("abort_lo", 64'(bus.lo), 64'h5678);
    repeat (40) tick();
    chk("abort_hilo_late", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

    // Same, with reset at cycle 20.
    issue(1'b1, 32'h0000_0009, 32'h0000_0009, 1'b0);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_reset_busy", 64'(bus.busy), 64'd0);
    chk("midrun_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrun_reset_ovf", 64'(bus.overflow), 64'd0);
    chk("midrun_reset_state", 64'(bus.state), 64'(IDLE));
    repeat (40) tick();

    // abort with start in IDLE: not accepted.
    bus.start = 1'b1; bus.abort = 1'b1; tick();
    clear_inputs();
    chk("abort_start_idle", 64'(bus.busy), 64'd0);

    // Simultaneous MTHI and MTLO.
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_5A5A; tick();
    clear_inputs();
    chk("mthi_mtlo", {bus.hi, bus.lo}, 64'hA5A5_5A5A_A5A5_5A5A);

    // Randomized operands against the reference model.
    for (int i = 0; i < 1500; i++) begin
      issue(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 1'b1);
      wait_done("rand", LAT);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
